// File: rtl/vend_pkg.sv
// vend_pkg: shared definitions for the multi-item vending controller.
//   - coin code constants (same encoding on the coin input and the res output)
//   - controller state encoding
//   - coin_value: coin code to value in nickels
//   - change_coin: remaining credit to the largest coin code not exceeding it
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_N    = 2'd1;  // 5c
    localparam logic [1:0] COIN_D    = 2'd2;  // 10c
    localparam logic [1:0] COIN_Q    = 2'd3;  // 25c

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_e;

    function automatic logic [2:0] coin_value(input logic [1:0] code);
        logic [2:0] v;
        case (code)
            COIN_N:  v = 3'd1;
            COIN_D:  v = 3'd2;
            COIN_Q:  v = 3'd5;
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    // Credit is in nickels; greedy largest-first return.
    function automatic logic [1:0] change_coin(input int unsigned credit);
        logic [1:0] c;
        if (credit >= 5) begin
            c = COIN_Q;
        end else if (credit >= 2) begin
            c = COIN_D;
        end else if (credit >= 1) begin
            c = COIN_N;
        end else begin
            c = COIN_NONE;
        end
        return c;
    endfunction

endpackage

// File: rtl/vend_multi_ctrl_if.sv
// vend_multi_ctrl_if: coin-acceptor / dispenser / hopper signal bundle.
//   coin        2        coin code from the acceptor
//   sel         SEL_W    item select, sampled with buy
//   buy         1        purchase request
//   cancel      1        return all credit
//   newspaper   N_ITEMS  one-hot dispense pulse
//   res         2        change coin code
//   credit      CREDIT_W current credit in nickels
//   busy        1        vending or returning change
//   coin_reject 1        rejected-coin pulse
// master: the front-end side driving requests; slave: the controller.
interface vend_multi_ctrl_if #(
    parameter int unsigned N_ITEMS  = 4,
    parameter int unsigned CREDIT_W = 5
);
    localparam int unsigned SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;

    logic [1:0]          coin;
    logic [SEL_W-1:0]    sel;
    logic                buy;
    logic                cancel;
    logic [N_ITEMS-1:0]  newspaper;
    logic [1:0]          res;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;

    modport master (
        output coin, sel, buy, cancel,
        input  newspaper, res, credit, busy, coin_reject
    );

    modport slave (
        input  coin, sel, buy, cancel,
        output newspaper, res, credit, busy, coin_reject
    );

endinterface

// File: rtl/vend_coin_detect.sv
// vend_coin_detect: coin insertion edge detector and value decoder.
//   clock       in   system clock
//   reset       in   synchronous active-low reset
//   coin        in   coin code from the acceptor
//   coin_event  out  coin present this cycle and absent the previous cycle
//   value       out  value of the present coin in nickels
module vend_coin_detect
    import vend_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       coin_event,
    output logic [2:0] value
);

    logic [1:0] prev_q;

    // Tracks the raw code every cycle, in all controller states, so a coin
    // held across a return to IDLE never produces a second event.
    always_ff @(posedge clock) begin
        if (!reset) begin
            prev_q <= COIN_NONE;
        end else begin
            prev_q <= coin;
        end
    end

    assign coin_event = (coin != COIN_NONE) && (prev_q == COIN_NONE);
    assign value      = coin_value(coin);

endmodule

// File: rtl/vend_multi_ctrl.sv
// vend_multi_ctrl: multi-item vending controller.
//   clock  in     system clock, rising edge
//   reset  in     synchronous active-low reset
//   bus    slave  coin/sel/buy/cancel in; newspaper/res/credit/busy/coin_reject out
// Credit is kept in nickels. Items vend on buy (or automatically for item 0
// when AUTO_VEND=1); change and cancelled credit return one coin per cycle,
// largest first. All outputs are registered.
module vend_multi_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned                 N_ITEMS    = 4,
    parameter int unsigned                 CREDIT_W   = 5,
    parameter int unsigned                 MAX_CREDIT = 20,
    parameter logic [N_ITEMS*CREDIT_W-1:0] PRICES     = {5'd10, 5'd7, 5'd5, 5'd3},
    parameter bit                          AUTO_VEND  = 1'b0
) (
    input logic             clock,
    input logic             reset,
    vend_multi_ctrl_if.slave bus
);

    localparam int unsigned W1 = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [N_ITEMS-1:0]  newspaper_q, newspaper_d;
    logic [1:0]          res_q, res_d;
    logic                busy_q, busy_d;
    logic                coin_reject_q, coin_reject_d;

    logic                coin_event;
    logic [2:0]          coin_val;

    logic                sel_valid;
    logic [CREDIT_W-1:0] sel_price;
    logic [N_ITEMS-1:0]  sel_onehot;

    logic [W1-1:0]       credit_w, sum_w, price_w, price0_w;
    logic [W1-1:0]       buy_rem_w, auto_rem_w, chg_rem_w;
    logic [1:0]          chg_code;

    logic                can_take, buy_req;
    logic                do_cancel, do_buy, do_auto, coin_ok;

    vend_coin_detect u_coin_detect (
        .clock      (clock),
        .reset      (reset),
        .coin       (bus.coin),
        .coin_event (coin_event),
        .value      (coin_val)
    );

    // Price mux; an out-of-range select leaves sel_valid low.
    always_comb begin
        sel_valid  = 1'b0;
        sel_price  = '0;
        sel_onehot = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (32'(bus.sel) == i) begin
                sel_valid     = 1'b1;
                sel_price     = PRICES[i*CREDIT_W +: CREDIT_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign credit_w   = W1'(credit_q);
    assign sum_w      = credit_w + W1'(coin_val);
    assign price_w    = W1'(sel_price);
    assign price0_w   = W1'(PRICES[CREDIT_W-1:0]);
    assign buy_rem_w  = credit_w - price_w;
    assign auto_rem_w = credit_w - price0_w;

    // Every path into or through CHANGE takes its coin from the registered
    // credit, so one change calculation serves cancel, VEND and CHANGE.
    assign chg_code  = change_coin(32'(credit_q));
    assign chg_rem_w = credit_w - W1'(coin_value(chg_code));

    assign can_take  = (state_q == IDLE) || (state_q == COLLECT);
    assign buy_req   = bus.buy && (AUTO_VEND == 1'b0);
    assign do_cancel = can_take && bus.cancel && (credit_q != '0);
    assign do_buy    = can_take && !bus.cancel && buy_req && sel_valid && (credit_w >= price_w);
    assign do_auto   = (AUTO_VEND == 1'b1) && (state_q == COLLECT) && !bus.cancel
                       && (credit_w >= price0_w);
    // A buy or cancel request blocks the coin even when the request itself
    // turns out to be ignored.
    assign coin_ok   = coin_event && can_take && !bus.cancel && !buy_req && !do_auto
                       && (sum_w <= W1'(MAX_CREDIT));

    // State and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            newspaper_q   <= '0;
            res_q         <= COIN_NONE;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            newspaper_q   <= newspaper_d;
            res_q         <= res_d;
            busy_q        <= busy_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (do_cancel) begin
                    state_d = CHANGE;
                end else if (do_buy || do_auto) begin
                    state_d = VEND;
                end else if (coin_ok) begin
                    state_d = COLLECT;
                end
            end
            VEND:    state_d = (credit_q != '0) ? CHANGE : IDLE;
            CHANGE:  state_d = (credit_q != '0) ? CHANGE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and credit.
    always_comb begin
        credit_d      = credit_q;
        newspaper_d   = '0;
        res_d         = COIN_NONE;
        coin_reject_d = coin_event && !coin_ok;
        case (state_q)
            IDLE, COLLECT: begin
                if (do_cancel) begin
                    res_d    = chg_code;
                    credit_d = CREDIT_W'(chg_rem_w);
                end else if (do_buy) begin
                    credit_d    = CREDIT_W'(buy_rem_w);
                    newspaper_d = sel_onehot;
                end else if (do_auto) begin
                    credit_d    = CREDIT_W'(auto_rem_w);
                    newspaper_d = N_ITEMS'(1);
                end else if (coin_ok) begin
                    credit_d = CREDIT_W'(sum_w);
                end
            end
            VEND, CHANGE: begin
                if (credit_q != '0) begin
                    res_d    = chg_code;
                    credit_d = CREDIT_W'(chg_rem_w);
                end
            end
            default: begin
                credit_d = '0;
            end
        endcase
        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    assign bus.newspaper   = newspaper_q;
    assign bus.res         = res_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;
    assign bus.coin_reject = coin_reject_q;

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// tb_vend_multi_ctrl: directed self-checking bench for vend_multi_ctrl.
// One default instance (explicit buy) and one AUTO_VEND instance share the
// clock and reset. Inputs change 1 ns after a rising edge; outputs are
// checked at the same point, reflecting the edge just taken.
module tb_vend_multi_ctrl;

    logic clock;
    logic reset;

    int checks   = 0;
    int failures = 0;

    vend_multi_ctrl_if #(.N_ITEMS(4), .CREDIT_W(5)) bus ();
    vend_multi_ctrl_if #(.N_ITEMS(4), .CREDIT_W(5)) bus_a ();

    vend_multi_ctrl #(
        .N_ITEMS    (4),
        .CREDIT_W   (5),
        .MAX_CREDIT (20),
        .PRICES     ({5'd10, 5'd7, 5'd5, 5'd3}),
        .AUTO_VEND  (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    vend_multi_ctrl #(
        .N_ITEMS    (4),
        .CREDIT_W   (5),
        .MAX_CREDIT (20),
        .PRICES     ({5'd10, 5'd7, 5'd5, 5'd3}),
        .AUTO_VEND  (1'b1)
    ) dut_auto (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] np, input logic [1:0] r,
                              input logic [4:0] cr, input logic bz, input logic rj);
        check({tag, ".newspaper"},   32'(bus.newspaper),   32'(np));
        check({tag, ".res"},         32'(bus.res),         32'(r));
        check({tag, ".credit"},      32'(bus.credit),      32'(cr));
        check({tag, ".busy"},        32'(bus.busy),        32'(bz));
        check({tag, ".coin_reject"}, 32'(bus.coin_reject), 32'(rj));
    endtask

    // Coin present for exactly one sampled edge; outputs then show its effect.
    task automatic coin_pulse(input logic [1:0] code);
        bus.coin = code;
        tick();
        bus.coin = 2'd0;
    endtask

    initial begin
        reset        = 1'b0;
        bus.coin     = 2'd0;
        bus.sel      = 2'd0;
        bus.buy      = 1'b0;
        bus.cancel   = 1'b0;
        bus_a.coin   = 2'd0;
        bus_a.sel    = 2'd0;
        bus_a.buy    = 1'b0;
        bus_a.cancel = 1'b0;
        tick();
        tick();
        expect_out("reset", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        check("reset_auto.credit", 32'(bus_a.credit), 32'd0);
        reset = 1'b1;
        tick();

        // Three separated nickels, then buy item 0 (price 3).
        coin_pulse(2'd1);
        expect_out("nickel1", 4'd0, 2'd0, 5'd1, 1'b0, 1'b0);
        tick();
        coin_pulse(2'd1);
        expect_out("nickel2", 4'd0, 2'd0, 5'd2, 1'b0, 1'b0);
        tick();
        coin_pulse(2'd1);
        expect_out("nickel3", 4'd0, 2'd0, 5'd3, 1'b0, 1'b0);
        tick();
        bus.buy = 1'b1;
        bus.sel = 2'd0;
        tick();
        bus.buy = 1'b0;
        expect_out("buy0_vend", 4'b0001, 2'd0, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("buy0_after", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Quarter, buy item 0, one dime of change.
        coin_pulse(2'd3);
        expect_out("quarter", 4'd0, 2'd0, 5'd5, 1'b0, 1'b0);
        tick();
        bus.buy = 1'b1;
        tick();
        bus.buy = 1'b0;
        expect_out("q_vend", 4'b0001, 2'd0, 5'd2, 1'b1, 1'b0);
        tick();
        expect_out("q_change", 4'd0, 2'd2, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("q_idle", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Held dime counts once.
        bus.coin = 2'd2;
        tick();
        tick();
        tick();
        expect_out("dime_held", 4'd0, 2'd0, 5'd2, 1'b0, 1'b0);
        bus.coin = 2'd0;
        tick();

        // Build to 18, quarter rejected at the ceiling.
        coin_pulse(2'd3);
        tick();
        coin_pulse(2'd3);
        tick();
        coin_pulse(2'd3);
        expect_out("credit17", 4'd0, 2'd0, 5'd17, 1'b0, 1'b0);
        tick();
        coin_pulse(2'd1);
        expect_out("credit18", 4'd0, 2'd0, 5'd18, 1'b0, 1'b0);
        tick();
        coin_pulse(2'd3);
        expect_out("over_max", 4'd0, 2'd0, 5'd18, 1'b0, 1'b1);
        tick();
        expect_out("over_max_after", 4'd0, 2'd0, 5'd18, 1'b0, 1'b0);

        // Cancel 18: 3,3,3,2,1.
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        expect_out("cancel_c1", 4'd0, 2'd3, 5'd13, 1'b1, 1'b0);
        tick();
        expect_out("cancel_c2", 4'd0, 2'd3, 5'd8, 1'b1, 1'b0);
        tick();
        expect_out("cancel_c3", 4'd0, 2'd3, 5'd3, 1'b1, 1'b0);
        tick();
        expect_out("cancel_c4", 4'd0, 2'd2, 5'd1, 1'b1, 1'b0);
        tick();
        expect_out("cancel_c5", 4'd0, 2'd1, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("cancel_idle", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Credit 5: unaffordable and affordable selections.
        coin_pulse(2'd3);
        tick();
        bus.buy = 1'b1;
        bus.sel = 2'd3;
        tick();
        expect_out("buy3_ignored", 4'd0, 2'd0, 5'd5, 1'b0, 1'b0);
        bus.sel = 2'd2;
        tick();
        expect_out("buy2_ignored", 4'd0, 2'd0, 5'd5, 1'b0, 1'b0);
        bus.sel = 2'd1;
        tick();
        bus.buy = 1'b0;
        expect_out("buy1_vend", 4'b0010, 2'd0, 5'd0, 1'b1, 1'b0);
        tick();
        expect_out("buy1_idle", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Buy and nickel together: nickel rejected, vend proceeds.
        coin_pulse(2'd2);
        tick();
        coin_pulse(2'd1);
        expect_out("credit3", 4'd0, 2'd0, 5'd3, 1'b0, 1'b0);
        tick();
        bus.buy  = 1'b1;
        bus.sel  = 2'd0;
        bus.coin = 2'd1;
        tick();
        bus.buy  = 1'b0;
        bus.coin = 2'd0;
        expect_out("buy_coin", 4'b0001, 2'd0, 5'd0, 1'b1, 1'b1);
        tick();
        expect_out("buy_coin_after", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Reset during CHANGE with 4 remaining.
        coin_pulse(2'd3);
        tick();
        coin_pulse(2'd2);
        tick();
        coin_pulse(2'd2);
        expect_out("credit9", 4'd0, 2'd0, 5'd9, 1'b0, 1'b0);
        tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        expect_out("cancel9_c1", 4'd0, 2'd3, 5'd4, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("mid_reset", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("post_reset", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);

        // Coin during CHANGE rejected; held coin does not retrigger in IDLE.
        coin_pulse(2'd3);
        tick();
        bus.cancel = 1'b1;
        tick();
        bus.cancel = 1'b0;
        expect_out("cancel5_c1", 4'd0, 2'd3, 5'd0, 1'b1, 1'b0);
        bus.coin = 2'd1;
        tick();
        expect_out("coin_in_change", 4'd0, 2'd0, 5'd0, 1'b0, 1'b1);
        tick();
        expect_out("coin_held_idle", 4'd0, 2'd0, 5'd0, 1'b0, 1'b0);
        bus.coin = 2'd0;
        tick();

        // AUTO_VEND: nickel then dime vends item 0 two cycles after the dime.
        bus_a.coin = 2'd1;
        tick();
        bus_a.coin = 2'd0;
        check("auto_nickel.credit", 32'(bus_a.credit), 32'd1);
        check("auto_nickel.newspaper", 32'(bus_a.newspaper), 32'd0);
        tick();
        bus_a.coin = 2'd2;
        tick();
        check("auto_dime.credit", 32'(bus_a.credit), 32'd3);
        check("auto_dime.newspaper", 32'(bus_a.newspaper), 32'd0);
        bus_a.coin = 2'd0;
        tick();
        check("auto_vend.newspaper", 32'(bus_a.newspaper), 32'd1);
        check("auto_vend.credit", 32'(bus_a.credit), 32'd0);
        check("auto_vend.busy", 32'(bus_a.busy), 32'd1);
        tick();
        check("auto_idle.newspaper", 32'(bus_a.newspaper), 32'd0);
        check("auto_idle.busy", 32'(bus_a.busy), 32'd0);
        check("auto_idle.res", 32'(bus_a.res), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
